keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 matrix keypad: drives one row low at a time, samples the synchronised column lines, and debounces presses and releases. Emits the binary row/column index of one debounced key plus a one-cycle strobe. Sits directly upstream of the keypad decoder and drives its `row`/`column` inputs (4-bit, value 0–3) with stable, debounced indices.

## Interface
- `SCAN_DIV`, 1000: clock cycles each row is driven (dwell); ≥ 4.
- `DEBOUNCE_CNT`, 8: consecutive matching samples required to accept a press or a release; ≥ 1.
- `clk` in 1: system clock; one clock domain.
- `rst` in 1: synchronous, active-high reset.
- `col_in` in 4: raw column lines, active-low (pulled up; pressed key pulls low), asynchronous.
- `row_drive` out 4: row strobes, active-low one-hot; row r driven ⇒ `row_drive = ~(4'b1 << r)`.
- `key_row` out 4: debounced row index 0–3, bits [3:2] always 0.
- `key_col` out 4: debounced column index 0–3, bits [3:2] always 0.
- `key_valid` out 1: one-cycle pulse when a new press is accepted.
- `key_held` out 1: high while the accepted key remains pressed.

## Operation
- `col_in` passes through a 2-flop synchroniser (reset value 4'b1111) → `col_s`.
- Dwell counter counts 0..SCAN_DIV-1 and wraps. A sample point is the cycle in which it equals SCAN_DIV-1. `col_s` is evaluated only at sample points.
- A sample is a *single hit* when exactly one bit of `col_s` is 0; its column index is that bit position. All-ones is *idle*; two or more zeros is *ghost*, treated as idle.
- States: SCAN, DEBOUNCE, PRESSED, RELEASE.
- SCAN: at each sample point, if single hit → latch candidate (current row, hit column), match count = 1, go DEBOUNCE, hold row. Otherwise advance row (3 wraps to 0).
- DEBOUNCE: row is frozen. At each sample point, a single hit on the candidate column increments the match count. On reaching DEBOUNCE_CNT: load `key_row`/`key_col`, pulse `key_valid`, go PRESSED. Any other sample → go SCAN and advance row; no outputs change.
- DEBOUNCE_CNT = 1: accept directly from SCAN (SCAN → PRESSED).
- PRESSED: `key_held` = 1; row frozen. At a sample point, a non-hit on the key's column (idle, ghost, or another column) → release count = 1, go RELEASE. With DEBOUNCE_CNT = 1, go straight to SCAN.
- RELEASE: `key_held` stays 1. A non-hit increments the release count; reaching DEBOUNCE_CNT → `key_held` = 0, go SCAN and advance row. A hit on the key column → back to PRESSED, count cleared, no new `key_valid`.
- `key_row`/`key_col` hold their last accepted value indefinitely; they change only in the cycle `key_valid` is asserted.
- Second key pressed while one is held: ignored until full release. No rollover.

## Timing
- Reset values: `row_drive` = 4'b1110, `key_row` = 0, `key_col` = 0, `key_valid` = 0, `key_held` = 0; state SCAN; all counters 0.
- Reset asserted in any state returns to the above on the next edge. A pending press is discarded and `key_valid` is never emitted.
- Cycle 0 = first cycle with `rst` low. `col_in` → `col_s` latency is 2 cycles. SCAN_DIV ≥ 4 guarantees the column lines have settled for ≥ 2 cycles after a row change before sampling.
- `row_drive` changes only in the cycle after a sample point. It is registered and glitch-free.
- Press latency: `key_valid` is asserted in the cycle after the DEBOUNCE_CNT-th consecutive matching sample.
- `key_held` rises together with `key_valid`. It falls in the cycle after the DEBOUNCE_CNT-th consecutive non-hit sample.

## Structure
- Package `keypad_pkg`: state enum (SCAN, DEBOUNCE, PRESSED, RELEASE); constants `KP_ROWS` = 4, `KP_COLS` = 4, `KP_COL_IDLE` = 4'b1111.
- Counter widths: `$clog2(SCAN_DIV)` and `$clog2(DEBOUNCE_CNT+1)`, local to the block.
- One sub-module: `keypad_sync`, a 4-bit 2-flop synchroniser with synchronous reset to all-ones.

## Test plan
- SCAN_DIV = 4, DEBOUNCE_CNT = 3; row 0 / col 2 held low from reset → `key_valid` pulses in cycle 12 with `key_row` = 0, `key_col` = 2; `key_held` = 1; `row_drive` stays 4'b1110.
- Row 2 / col 1 pressed, then released → `key_row` = 2, `key_col` = 1; `key_held` falls 3 sample points after release; scanning resumes at row 3 (`row_drive` = 4'b0111).
- Bounce: press lasts 2 samples, releases for 1, then holds → no pulse during the bounce; exactly one `key_valid` after 3 clean consecutive samples.
- Ghost: two columns low on row 1 → no `key_valid`; rows keep cycling 1110 → 1101 → 1011 → 0111 → 1110.
- Release bounce: in RELEASE, column goes low again after 1 idle sample → `key_held` stays 1; no second `key_valid`.
- `rst` pulsed mid-DEBOUNCE → all outputs at reset values next cycle; no `key_valid`.

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : keypad_pkg                                                    |
// | Purpose  : Shared types, constants and the column-decode helper for the  |
// |            4x4 matrix keypad scanner.                                    |
// | Contents : kp_state_e  - scanner FSM states                              |
// |            kp_hit_t    - decoded column sample (hit flag + index)        |
// |            kp_decode() - classifies a column sample as hit/idle/ghost    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package keypad_pkg;

  localparam int          KP_ROWS     = 4;
  localparam int          KP_COLS     = 4;
  localparam logic [3:0]  KP_COL_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] col;
  } kp_hit_t;

  // A sample is a hit only when exactly one column is pulled low. Idle and
  // multi-column (ghost) patterns both decode as "no hit".
  function automatic kp_hit_t kp_decode(input logic [KP_COLS-1:0] cols);
    kp_hit_t r;
    r.hit = 1'b1;
    r.col = 2'd0;
    case (cols)
      4'b1110: r.col = 2'd0;
      4'b1101: r.col = 2'd1;
      4'b1011: r.col = 2'd2;
      4'b0111: r.col = 2'd3;
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : keypad_scanner_if                                             |
// | Purpose  : Bundles the keypad matrix lines and the debounced key outputs |
// |            between the scanner and its surroundings.                     |
// | Signals  : col_in    - raw column lines, active-low, asynchronous        |
// |            row_drive - active-low one-hot row strobes                    |
// |            key_row   - debounced row index (0-3, bits [3:2] zero)        |
// |            key_col   - debounced column index (0-3, bits [3:2] zero)     |
// |            key_valid - one-cycle pulse on each accepted press            |
// |            key_held  - high while the accepted key remains pressed       |
// | Modports : master - the scanner; slave - keypad/decoder side             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [KP_COLS-1:0] col_in;
  logic [KP_ROWS-1:0] row_drive;
  logic [3:0]         key_row;
  logic [3:0]         key_col;
  logic               key_valid;
  logic               key_held;

  modport master (
    input  col_in,
    output row_drive,
    output key_row,
    output key_col,
    output key_valid,
    output key_held
  );

  modport slave (
    output col_in,
    input  row_drive,
    input  key_row,
    input  key_col,
    input  key_valid,
    input  key_held
  );

endinterface
`default_nettype wire

// File: rtl/keypad_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : keypad_sync                                                   |
// | Purpose  : 2-flop synchroniser for the asynchronous column lines.        |
// |            Resets to all-ones so the lines read as idle out of reset.    |
// | Ports    : clk - clock; rst - synchronous active-high reset              |
// |            d_i - asynchronous input; q_o - synchronised output           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module keypad_sync
  import keypad_pkg::*;
(
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic [KP_COLS-1:0]  d_i,
  output logic      [KP_COLS-1:0]  q_o
);

  logic [KP_COLS-1:0] meta_q;
  logic [KP_COLS-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= KP_COL_IDLE;
      sync_q <= KP_COL_IDLE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : keypad_scanner                                                |
// | Purpose  : Scans a 4x4 matrix keypad one row at a time, debounces press  |
// |            and release, and reports the row/column index of one key      |
// |            with a single-cycle strobe.                                   |
// | Params   : SCAN_DIV     - cycles each row is driven (>= 4)               |
// |            DEBOUNCE_CNT - matching samples to accept press/release (>=1) |
// | Ports    : clk - clock; rst - synchronous active-high reset              |
// |            kp  - keypad_scanner_if.master (col_in in; row_drive,         |
// |                  key_row, key_col, key_valid, key_held out)              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  keypad_scanner_if.master   kp
);

  localparam int RW = $clog2(KP_ROWS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_TGT     = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  // With a single-sample debounce the first hit is already accepted and the
  // first miss is already a full release, so DEBOUNCE/RELEASE are skipped.
  localparam bit            DB_ONE     = (DEBOUNCE_CNT == 1);

  logic [KP_COLS-1:0] col_s;

  keypad_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (kp.col_in),
    .q_o (col_s)
  );

  kp_state_e          state_q,     state_d;
  logic [DW-1:0]      dwell_q,     dwell_d;
  logic [CW-1:0]      cnt_q,       cnt_d;
  logic [RW-1:0]      row_q,       row_d;
  logic [KP_ROWS-1:0] row_drive_q, row_drive_d;
  logic [1:0]         cand_col_q,  cand_col_d;
  logic [1:0]         key_row_q,   key_row_d;
  logic [1:0]         key_col_q,   key_col_d;
  logic               key_valid_q, key_valid_d;
  logic               key_held_q,  key_held_d;

  kp_hit_t            dec;
  logic               sample;
  logic               hit_cand;
  logic               hit_key;
  logic [CW-1:0]      cnt_inc;
  logic [RW-1:0]      row_next;

  assign dec      = kp_decode(col_s);
  assign sample   = (dwell_q == DWELL_LAST);
  assign hit_cand = dec.hit && (dec.col == cand_col_q);
  assign hit_key  = dec.hit && (dec.col == key_col_q);
  assign cnt_inc  = cnt_q + 1'b1;
  assign row_next = row_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    dwell_d     = sample ? '0 : dwell_q + 1'b1;
    cnt_d       = cnt_q;
    row_d       = row_q;
    cand_col_d  = cand_col_q;
    key_row_d   = key_row_q;
    key_col_d   = key_col_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    if (sample) begin
      case (state_q)
        SCAN: begin
          if (dec.hit) begin
            if (DB_ONE) begin
              key_row_d   = row_q;
              key_col_d   = dec.col;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = '0;
              state_d     = PRESSED;
            end else begin
              cand_col_d  = dec.col;
              cnt_d       = CNT_ONE;
              state_d     = DEBOUNCE;
            end
          end else begin
            row_d = row_next;
          end
        end

        DEBOUNCE: begin
          if (hit_cand) begin
            if (cnt_inc == DB_TGT) begin
              key_row_d   = row_q;
              key_col_d   = cand_col_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = '0;
              state_d     = PRESSED;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            // A broken run of samples abandons the candidate entirely.
            cnt_d   = '0;
            row_d   = row_next;
            state_d = SCAN;
          end
        end

        PRESSED: begin
          if (!hit_key) begin
            if (DB_ONE) begin
              key_held_d = 1'b0;
              cnt_d      = '0;
              row_d      = row_next;
              state_d    = SCAN;
            end else begin
              cnt_d   = CNT_ONE;
              state_d = RELEASE;
            end
          end
        end

        RELEASE: begin
          if (hit_key) begin
            // Release bounce: key is still down, no fresh strobe.
            cnt_d   = '0;
            state_d = PRESSED;
          end else if (cnt_inc == DB_TGT) begin
            key_held_d = 1'b0;
            cnt_d      = '0;
            row_d      = row_next;
            state_d    = SCAN;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        default: begin
          cnt_d   = '0;
          state_d = SCAN;
        end
      endcase
    end

    // Row strobes are registered from the next row index so the pins only
    // move in the cycle after a sample point and never glitch.
    row_drive_d = ~(KP_ROWS'(1) << row_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      dwell_q     <= '0;
      cnt_q       <= '0;
      row_q       <= '0;
      row_drive_q <= 4'b1110;
      cand_col_q  <= 2'd0;
      key_row_q   <= 2'd0;
      key_col_q   <= 2'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      row_drive_q <= row_drive_d;
      cand_col_q  <= cand_col_d;
      key_row_q   <= key_row_d;
      key_col_q   <= key_col_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign kp.row_drive = row_drive_q;
  assign kp.key_row   = {2'b00, key_row_q};
  assign kp.key_col   = {2'b00, key_col_q};
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_keypad_scanner                                             |
// | Purpose  : Directed self-checking bench for keypad_scanner with          |
// |            SCAN_DIV = 4 and DEBOUNCE_CNT = 3. A small matrix model turns |
// |            the pressed-key map and row strobes into column levels.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_keypad_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if kif();

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif)
  );

  // pressed[r][c] = key at row r, column c is held down
  logic [3:0] pressed [4];
  logic [3:0] col_lvl;

  always_comb begin
    col_lvl = 4'b1111;
    for (int r = 0; r < 4; r++)
      if (kif.row_drive[r] == 1'b0) col_lvl = col_lvl & ~pressed[r];
    kif.col_in = col_lvl;
  end

  // Cycle index: in cycle k (after the k-th edge with rst low) cyc == k.
  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int vcount = 0;
  always @(negedge clk) if (kif.key_valid === 1'b1) vcount++;

  int n_checks = 0;
  int n_fail   = 0;
  int v0, v1, v2;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
    // Key (0,2) is held from reset onwards.
    pressed[0][2] = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_row_drive", kif.row_drive, 4'b1110);
    check("rst_key_row",   kif.key_row,   4'd0);
    check("rst_key_col",   kif.key_col,   4'd0);
    check("rst_key_valid", {3'b0, kif.key_valid}, 4'd0);
    check("rst_key_held",  {3'b0, kif.key_held},  4'd0);
    rst = 1'b0;

    // Press from reset: samples at cycles 3, 7, 11 -> strobe in cycle 12.
    wait_cyc(11);
    check("t1_valid_pre", {3'b0, kif.key_valid}, 4'd0);
    wait_cyc(12);
    check("t1_valid",     {3'b0, kif.key_valid}, 4'd1);
    check("t1_key_row",   kif.key_row,   4'd0);
    check("t1_key_col",   kif.key_col,   4'd2);
    check("t1_held",      {3'b0, kif.key_held}, 4'd1);
    check("t1_row_drive", kif.row_drive, 4'b1110);
    wait_cyc(13);
    check("t1_valid_1cyc", {3'b0, kif.key_valid}, 4'd0);
    pressed[0][2] = 1'b0;
    wait_cyc(23);
    check("t1_held_pre_rel", {3'b0, kif.key_held}, 4'd1);
    wait_cyc(24);
    check("t1_held_fall",  {3'b0, kif.key_held}, 4'd0);
    check("t1_row_adv",    kif.row_drive, 4'b1101);
    check("t1_key_col_hold", kif.key_col, 4'd2);

    // Key (2,1): row 2 driven from cycle 28, samples 31/35/39.
    pressed[2][1] = 1'b1;
    wait_cyc(28);
    check("t2_row2", kif.row_drive, 4'b1011);
    wait_cyc(39);
    check("t2_valid_pre", {3'b0, kif.key_valid}, 4'd0);
    wait_cyc(40);
    check("t2_valid",   {3'b0, kif.key_valid}, 4'd1);
    check("t2_key_row", kif.key_row, 4'd2);
    check("t2_key_col", kif.key_col, 4'd1);
    check("t2_held",    {3'b0, kif.key_held}, 4'd1);
    wait_cyc(41);
    pressed[2][1] = 1'b0;
    wait_cyc(51);
    check("t2_held_pre_rel", {3'b0, kif.key_held}, 4'd1);
    wait_cyc(52);
    check("t2_held_fall", {3'b0, kif.key_held}, 4'd0);
    check("t2_row3",      kif.row_drive, 4'b0111);
    check("t2_key_row_hold", kif.key_row, 4'd2);

    // Press bounce on (0,3): hits at 59, 63, idle at 67, then clean 83/87/91.
    v0 = vcount;
    pressed[0][3] = 1'b1;
    wait_cyc(64);
    check("t3_row_frozen", kif.row_drive, 4'b1110);
    pressed[0][3] = 1'b0;
    wait_cyc(68);
    check("t3_abandon_adv", kif.row_drive, 4'b1101);
    pressed[0][3] = 1'b1;
    wait_cyc(91);
    check("t3_no_pulse", 4'(vcount - v0), 4'd0);
    check("t3_held_pre", {3'b0, kif.key_held}, 4'd0);
    wait_cyc(92);
    check("t3_valid",   {3'b0, kif.key_valid}, 4'd1);
    check("t3_key_row", kif.key_row, 4'd0);
    check("t3_key_col", kif.key_col, 4'd3);
    wait_cyc(93);
    pressed[0][3] = 1'b0;
    wait_cyc(104);
    check("t3_held_fall", {3'b0, kif.key_held}, 4'd0);
    check("t3_row1",      kif.row_drive, 4'b1101);

    // Ghost: (1,0) and (1,2) together never register; rows keep cycling.
    pressed[1][0] = 1'b1;
    pressed[1][2] = 1'b1;
    wait_cyc(108);
    check("t4_row_a", kif.row_drive, 4'b1011);
    wait_cyc(112);
    check("t4_row_b", kif.row_drive, 4'b0111);
    wait_cyc(116);
    check("t4_row_c", kif.row_drive, 4'b1110);
    wait_cyc(120);
    check("t4_row_d", kif.row_drive, 4'b1101);
    wait_cyc(124);
    check("t4_no_pulse", 4'(vcount - v0), 4'd1);
    check("t4_held",     {3'b0, kif.key_held}, 4'd0);
    pressed[1][0] = 1'b0;
    pressed[1][2] = 1'b0;

    // Release bounce on (2,3): accepted at 136, one idle sample at 139,
    // key back down for 143 -> stays held, no second strobe.
    v1 = vcount;
    pressed[2][3] = 1'b1;
    wait_cyc(136);
    check("t5_valid",   {3'b0, kif.key_valid}, 4'd1);
    check("t5_key_row", kif.key_row, 4'd2);
    check("t5_key_col", kif.key_col, 4'd3);
    pressed[2][3] = 1'b0;
    wait_cyc(140);
    check("t5_held_in_release", {3'b0, kif.key_held}, 4'd1);
    pressed[2][3] = 1'b1;
    wait_cyc(160);
    check("t5_held_still", {3'b0, kif.key_held}, 4'd1);
    check("t5_one_pulse",  4'(vcount - v1), 4'd1);
    check("t5_row_frozen", kif.row_drive, 4'b1011);
    pressed[2][3] = 1'b0;
    wait_cyc(171);
    check("t5_held_pre_rel", {3'b0, kif.key_held}, 4'd1);
    wait_cyc(172);
    check("t5_held_fall", {3'b0, kif.key_held}, 4'd0);
    check("t5_row3",      kif.row_drive, 4'b0111);

    // Reset mid-DEBOUNCE on (3,1): hits at 175 and 179, reset before 183.
    pressed[3][1] = 1'b1;
    wait_cyc(180);
    check("t6_row_frozen", kif.row_drive, 4'b0111);
    v2 = vcount;
    pressed[3][1] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_row_drive", kif.row_drive, 4'b1110);
    check("t6_rst_key_row",   kif.key_row,   4'd0);
    check("t6_rst_key_col",   kif.key_col,   4'd0);
    check("t6_rst_valid",     {3'b0, kif.key_valid}, 4'd0);
    check("t6_rst_held",      {3'b0, kif.key_held},  4'd0);
    rst = 1'b0;
    wait_cyc(20);
    check("t6_no_pulse", 4'(vcount - v2), 4'd0);
    check("t6_held",     {3'b0, kif.key_held}, 4'd0);
    check("t6_row1",     kif.row_drive, 4'b1101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
